// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scanner
// Purpose  : Multiplexed common-anode 7-segment driver with a double-buffered
//            frame, dead time between digits and leading-zero blanking.
// Revision : 1.0
// ============================================================================
module seven_segment_scanner #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 500,
   parameter int LZ_BLANK    = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic                    load,
   input  logic                    enable,
   output logic [6:0]              seven,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_tick
);
   localparam int c_cnt_w = $clog2(REFRESH_DIV);
   localparam int c_idx_w = $clog2(NUM_DIGITS);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
   localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);

   logic [c_cnt_w-1:0]      cnt_q, cnt_d;
   logic [c_idx_w-1:0]      idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] sh_value_q, disp_value_q;
   logic [NUM_DIGITS-1:0]   sh_dp_q, disp_dp_q;
   logic [NUM_DIGITS-1:0]   sh_blank_q, disp_blank_q;
   logic [6:0]              seven_q, seven_d;
   logic                    dp_n_q, dp_n_d;
   logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
   logic                    frame_tick_q;

   logic                    w_slot_end;
   logic                    w_frame_end;
   logic                    w_past_dead;
   logic [NUM_DIGITS-1:0]   w_lz;
   logic [NUM_DIGITS:1]     w_zero_from;
   logic [NUM_DIGITS-1:0]   w_onehot;
   logic [3:0]              w_digit;
   logic                    w_dp;
   logic                    w_dark;
   logic                    w_lit;

   function automatic logic [6:0] f_decode(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign w_slot_end  = (cnt_q == c_cnt_last);
   assign w_frame_end = w_slot_end && (idx_q == c_idx_last);

   always_comb begin
      cnt_d = w_slot_end ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (w_slot_end) begin
         idx_d = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;
      end
   end

   if (DEAD_CYCLES == 0) begin : g_no_dead
      assign w_past_dead = 1'b1;
   end else begin : g_dead
      assign w_past_dead = (cnt_q >= c_cnt_w'(DEAD_CYCLES));
   end

   // w_zero_from[i] is set when display digits i..NUM_DIGITS-1 are all zero
   assign w_zero_from[NUM_DIGITS] = 1'b1;
   for (genvar gi = NUM_DIGITS - 1; gi >= 1; gi--) begin : g_zero_chain
      assign w_zero_from[gi] = w_zero_from[gi+1] && (disp_value_q[4*gi +: 4] == 4'h0);
   end

   if (LZ_BLANK != 0) begin : g_lz_on
      assign w_lz = {w_zero_from[NUM_DIGITS-1:1], 1'b0};
   end else begin : g_lz_off
      assign w_lz = '0;
   end

   always_comb begin
      w_digit  = 4'h0;
      w_dp     = 1'b0;
      w_dark   = 1'b0;
      w_onehot = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == c_idx_w'(i)) begin
            w_digit     = disp_value_q[4*i +: 4];
            w_dp        = disp_dp_q[i];
            w_dark      = disp_blank_q[i] | w_lz[i];
            w_onehot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      w_lit   = enable && w_past_dead && !w_dark;
      seven_d = 7'b1111111;
      dp_n_d  = 1'b1;
      an_n_d  = '1;
      if (w_lit) begin
         seven_d = f_decode(w_digit);
         dp_n_d  = ~w_dp;
         an_n_d  = ~w_onehot;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         sh_value_q   <= '0;
         sh_dp_q      <= '0;
         sh_blank_q   <= '0;
         disp_value_q <= '0;
         disp_dp_q    <= '0;
         disp_blank_q <= '0;
         seven_q      <= 7'b1111111;
         dp_n_q       <= 1'b1;
         an_n_q       <= '1;
         frame_tick_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         seven_q      <= seven_d;
         dp_n_q       <= dp_n_d;
         an_n_q       <= an_n_d;
         frame_tick_q <= w_frame_end;
         if (load) begin
            sh_value_q <= value;
            sh_dp_q    <= dp_mask;
            sh_blank_q <= blank_mask;
         end
         // Display takes the shadow as it was before any same-cycle load
         if (w_frame_end) begin
            disp_value_q <= sh_value_q;
            disp_dp_q    <= sh_dp_q;
            disp_blank_q <= sh_blank_q;
         end
      end
   end

   assign seven      = seven_q;
   assign dp_n       = dp_n_q;
   assign an_n       = an_n_q;
   assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
